// File: rtl/conv2d_seq_ctrl.sv
// Frame-level sequencer for one 3x3 conv2d datapath: clear, kernel load,
// pixel streaming, result tagging and drain timeout.
module conv2d_seq_ctrl #(
  parameter int IMG_W         = 28,
  parameter int IMG_H         = 28,
  parameter int KWORDS        = 9,
  parameter int DRAIN_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic [31:0] ker_data,
  input  logic        ker_valid,
  output logic        ker_ready,
  input  logic [31:0] px_data,
  input  logic        px_valid,
  output logic        px_ready,
  output logic        dp_reset,
  output logic [31:0] dp_kernel_in,
  output logic [31:0] dp_data_in,
  output logic        dp_valid_in,
  input  logic        dp_load_kernel_done,
  input  logic        dp_valid_out,
  input  logic [31:0] dp_data_out,
  output logic [31:0] res_data,
  output logic        res_valid,
  output logic        res_last
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned NRES = (IMG_W - 2) * (IMG_H - 2);
  localparam int unsigned KW   = $clog2(KWORDS + 1);
  localparam int unsigned PW   = $clog2(NPIX + 1);
  localparam int unsigned OW   = $clog2(NRES + 1);
  localparam int unsigned TW   = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [KW-1:0] K_LAST = KW'(KWORDS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(NPIX - 1);
  localparam logic [OW-1:0] O_TGT  = OW'(NRES);
  localparam logic [OW-1:0] O_LAST = OW'(NRES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD_K, S_WAIT_K, S_STREAM, S_DRAIN, S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] kcnt_q, kcnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [OW-1:0] ocnt_q, ocnt_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          error_q, error_d;
  logic [31:0]   kdata_q, kdata_d;
  logic [31:0]   pdata_q, pdata_d;
  logic          pvalid_q, pvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          rlast_q, rlast_d;

  logic k_acc, p_acc, res_acc, final_seen;

  always_comb begin
    state_d  = state_q;
    kcnt_d   = kcnt_q;
    pcnt_d   = pcnt_q;
    ocnt_d   = ocnt_q;
    idle_d   = '0;
    error_d  = error_q;
    kdata_d  = kdata_q;
    pdata_d  = pdata_q;
    pvalid_d = 1'b0;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    rlast_d  = 1'b0;

    k_acc   = (state_q == S_LOAD_K) && ker_valid;
    p_acc   = (state_q == S_STREAM) && px_valid;
    // Results only count while streaming/draining and never past the target.
    res_acc = ((state_q == S_STREAM) || (state_q == S_DRAIN)) && dp_valid_out
              && (ocnt_q < O_TGT);
    final_seen = (ocnt_q == O_TGT) || (res_acc && (ocnt_q == O_LAST));

    if (res_acc) begin
      rdata_d  = dp_data_out;
      rvalid_d = 1'b1;
      rlast_d  = (ocnt_q == O_LAST);
      ocnt_d   = ocnt_q + OW'(1);
    end
    if (k_acc) begin
      kdata_d = ker_data;
      kcnt_d  = kcnt_q + KW'(1);
    end
    if (p_acc) begin
      pdata_d  = px_data;
      pvalid_d = 1'b1;
      pcnt_d   = pcnt_q + PW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          error_d = 1'b0;
          kcnt_d  = '0;
          pcnt_d  = '0;
          ocnt_d  = '0;
        end
      end
      S_CLEAR:  state_d = S_LOAD_K;
      S_LOAD_K: if (k_acc && (kcnt_q == K_LAST)) state_d = S_WAIT_K;
      S_WAIT_K: if (dp_load_kernel_done) state_d = S_STREAM;
      S_STREAM: if (p_acc && (pcnt_q == P_LAST)) state_d = S_DRAIN;
      S_DRAIN: begin
        // Timeout fires on the DRAIN_TIMEOUT-th consecutive idle cycle.
        idle_d = dp_valid_out ? '0 : idle_q + TW'(1);
        if (final_seen) begin
          state_d = S_FIN;
        end else if (!dp_valid_out && (idle_q == T_LAST)) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      kcnt_q   <= '0;
      pcnt_q   <= '0;
      ocnt_q   <= '0;
      idle_q   <= '0;
      error_q  <= 1'b0;
      kdata_q  <= '0;
      pdata_q  <= '0;
      pvalid_q <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      kcnt_q   <= kcnt_d;
      pcnt_q   <= pcnt_d;
      ocnt_q   <= ocnt_d;
      idle_q   <= idle_d;
      error_q  <= error_d;
      kdata_q  <= kdata_d;
      pdata_q  <= pdata_d;
      pvalid_q <= pvalid_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
    end
  end

  // dp_reset follows the reset input directly so a mid-frame reset flushes at once.
  assign dp_reset     = reset && (state_q != S_CLEAR);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FIN) && !error_q;
  assign error        = error_q;
  assign ker_ready    = (state_q == S_LOAD_K);
  assign px_ready     = (state_q == S_STREAM);
  assign dp_kernel_in = kdata_q;
  assign dp_data_in   = pdata_q;
  assign dp_valid_in  = pvalid_q;
  assign res_data     = rdata_q;
  assign res_valid    = rvalid_q;
  assign res_last     = rlast_q;

endmodule

// File: tb/tb_conv2d_seq_ctrl.sv
// Bench for conv2d_seq_ctrl on a 5x5 frame: a reactive datapath model plus a
// table of frame scenarios and hand sequences for reset and start corners.
module tb_conv2d_seq_ctrl;

  localparam int IW = 5;
  localparam int IH = 5;
  localparam int C_KER = 0, C_DVI = 1, C_RES = 2, C_LAST = 3;
  localparam int C_DONE = 4, C_CLR = 5, C_WAIT = 6, C_BAD = 7;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, error;
  logic [31:0] ker_data, px_data;
  logic        ker_valid, ker_ready, px_valid, px_ready;
  logic        dp_reset, dp_valid_in, dp_load_kernel_done, dp_valid_out;
  logic [31:0] dp_kernel_in, dp_data_in, dp_data_out;
  logic [31:0] res_data;
  logic        res_valid, res_last;

  conv2d_seq_ctrl #(.IMG_W(IW), .IMG_H(IH), .KWORDS(9), .DRAIN_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .error(error),
    .ker_data(ker_data), .ker_valid(ker_valid), .ker_ready(ker_ready),
    .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
    .dp_reset(dp_reset), .dp_kernel_in(dp_kernel_in), .dp_data_in(dp_data_in),
    .dp_valid_in(dp_valid_in), .dp_load_kernel_done(dp_load_kernel_done),
    .dp_valid_out(dp_valid_out), .dp_data_out(dp_data_out),
    .res_data(res_data), .res_valid(res_valid), .res_last(res_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit tog; int lat; int lim; int kdl; bit kforce; bit smid;
    int e_ker; int e_dvi; int e_res; int e_last; int e_done; int e_err; int e_wait;
    bit chk_to;
  } row_t;

  int errors = 0;
  int checks = 0;

  // Observation state, owned by the monitor/model process.
  int cnt [8];
  int cyc = 0, mk = 0, last_at = 0, e_lres = 0, e_err = 0, e_idle = 0;
  bit k_acc, p_acc, kr_prev, pr_prev, err_prev, bsy_prev, kph;
  int mpix, kdc, npush;
  int dq[$];
  logic [31:0] ddq[$];
  logic [31:0] expq[$];

  // Datapath model knobs, set by the stimulus process between frames.
  int lat = 0, lim = 9, kdl = 0;
  bit kforce = 1'b0;

  int base [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] ovec();
    return {busy, done, error, ker_ready, px_ready, dp_valid_in, res_valid, res_last, dp_reset};
  endfunction

  // Monitor at negedge (inputs still hold the values sampled at the last posedge),
  // then the datapath model drives its outputs for the next posedge.
  initial begin
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    dp_valid_out = 1'b0; dp_data_out = '0; dp_load_kernel_done = 1'b0;
    mpix = 0; kdc = 0; npush = 0;
    forever begin
      @(negedge clk);
      cyc++;
      k_acc = (ker_valid === 1'b1) && kr_prev;
      p_acc = (px_valid === 1'b1) && pr_prev;
      if (dp_reset !== 1'b1) mk = 0;
      else if (k_acc) mk++;
      if (k_acc) begin
        cnt[C_KER]++;
        if (dp_kernel_in !== ker_data) cnt[C_BAD]++;
      end
      if (dp_valid_in === 1'b1) cnt[C_DVI]++;
      if (dp_valid_in !== p_acc) cnt[C_BAD]++;
      if (p_acc && (dp_data_in !== px_data)) cnt[C_BAD]++;
      if (res_valid === 1'b1) begin
        cnt[C_RES]++;
        if (expq.size() == 0) cnt[C_BAD]++;
        else if (res_data !== expq.pop_front()) cnt[C_BAD]++;
        if (res_last === 1'b1) begin cnt[C_LAST]++; last_at = cnt[C_RES]; end
      end else if (res_last === 1'b1) cnt[C_BAD]++;
      if (done === 1'b1) cnt[C_DONE]++;
      if (dp_reset === 1'b0 && reset === 1'b1) cnt[C_CLR]++;
      if (ker_ready === 1'b1) kph = 1'b1;
      if (px_ready === 1'b1) kph = 1'b0;
      if (kph && busy === 1'b1 && ker_ready === 1'b0 && px_ready === 1'b0) cnt[C_WAIT]++;
      if (dp_valid_out) e_lres = cyc;
      if (error === 1'b1 && !err_prev) e_err = cyc;
      if (busy === 1'b0 && bsy_prev) e_idle = cyc;
      kr_prev = (ker_ready === 1'b1); pr_prev = (px_ready === 1'b1);
      err_prev = (error === 1'b1);    bsy_prev = (busy === 1'b1);

      #1;
      if (dp_reset === 1'b0) begin
        mpix = 0; kdc = 0; npush = 0;
        dq.delete(); ddq.delete(); expq.delete();
      end else if (dp_valid_in === 1'b1) begin
        if ((mpix / IW) >= 2 && (mpix % IW) >= 2 && npush < lim) begin
          dq.push_back(cyc + lat);
          ddq.push_back(32'hA500_0000 + 32'(mpix));
          npush++;
        end
        mpix++;
      end
      if (mk >= 9) kdc++;
      dp_load_kernel_done = kforce || (mk >= 9 && kdc > kdl);
      dp_valid_out = 1'b0;
      if (dq.size() > 0 && dq[0] <= cyc) begin
        void'(dq.pop_front());
        dp_valid_out = 1'b1;
        dp_data_out  = ddq.pop_front();
        expq.push_back(dp_data_out);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic run_frame(input row_t r, input int abort_at);
    int idx, g;
    bit ph;
    lat = r.lat; lim = r.lim; kdl = r.kdl; kforce = r.kforce;
    for (int i = 0; i < 8; i++) base[i] = cnt[i];
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_clears_error", {31'd0, error}, 32'd0);
    chk("busy_after_start", {31'd0, busy}, 32'd1);

    idx = 0; g = 0; ph = 1'b1;
    while (idx < 9 && g < 300) begin
      ker_valid = r.tog ? ph : 1'b1;
      ker_data  = 32'(idx + 1);
      step(); g++;
      if (k_acc) idx++;
      ph = ~ph;
    end
    ker_valid = 1'b0;
    chk("kernel_budget", 32'(idx), 32'd9);

    idx = 0; g = 0; ph = 1'b1;
    while (idx < IW * IH && g < 300) begin
      px_valid = r.tog ? ph : 1'b1;
      px_data  = 32'h0100_0000 + 32'(idx);
      step(); g++;
      start = 1'b0;
      if (p_acc) begin
        idx++;
        if (r.smid && idx == 10) start = 1'b1;
        if (idx == abort_at) begin
          reset = 1'b0; px_valid = 1'b0;
          #1;
          chk("abort_dp_reset_now", {31'd0, dp_reset}, 32'd0);
          @(negedge clk);
          chk("abort_ctrl", {23'd0, ovec()}, 32'd0);
          chk("abort_res_data", res_data, 32'd0);
          chk("abort_dp_data_in", dp_data_in, 32'd0);
          chk("abort_dp_kernel_in", dp_kernel_in, 32'd0);
          #2;
          reset = 1'b1;
          return;
        end
      end
      ph = ~ph;
    end
    px_valid = 1'b0;
    start = 1'b0;
    chk("pixel_budget", 32'(idx), 32'(IW * IH));

    g = 0;
    while (busy === 1'b1 && g < 300) begin
      step(); g++;
      start = r.smid && (done === 1'b1);
    end
    start = 1'b0;
    chk("drain_budget", {31'd0, busy}, 32'd0);
    repeat (3) step();
    chk("idle_after_frame", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_row(input row_t r, input int n);
    string s;
    s = $sformatf("r%0d_", n);
    chk({s, "ker_accepts"}, 32'(cnt[C_KER] - base[C_KER]), 32'(r.e_ker));
    chk({s, "dp_valid_in"}, 32'(cnt[C_DVI] - base[C_DVI]), 32'(r.e_dvi));
    chk({s, "res_valid"},   32'(cnt[C_RES] - base[C_RES]), 32'(r.e_res));
    chk({s, "res_last"},    32'(cnt[C_LAST] - base[C_LAST]), 32'(r.e_last));
    chk({s, "done"},        32'(cnt[C_DONE] - base[C_DONE]), 32'(r.e_done));
    chk({s, "clear_cycles"}, 32'(cnt[C_CLR] - base[C_CLR]), 32'd1);
    chk({s, "waitk_cycles"}, 32'(cnt[C_WAIT] - base[C_WAIT]), 32'(r.e_wait));
    chk({s, "data_viol"},   32'(cnt[C_BAD] - base[C_BAD]), 32'd0);
    chk({s, "error"},       {31'd0, error}, 32'(r.e_err));
    if (r.e_last != 0) chk({s, "last_index"}, 32'(last_at - base[C_RES]), 32'(r.e_res));
    if (r.chk_to) begin
      chk({s, "timeout_gap"}, 32'(e_err - e_lres), 32'd16);
      chk({s, "busy_fall"},   32'(e_idle - e_err), 32'd1);
    end
  endtask

  initial begin
    row_t rows [6];
    //          tog lat lim kdl kf smid  ker dvi res last done err wait to
    rows[0] = '{1'b0, 0,  9, 0, 1'b0, 1'b0, 9, 25, 9, 1, 1, 0, 1, 1'b0};
    rows[1] = '{1'b1, 0,  9, 0, 1'b0, 1'b0, 9, 25, 9, 1, 1, 0, 1, 1'b0};
    rows[2] = '{1'b0, 3,  9, 3, 1'b0, 1'b0, 9, 25, 9, 1, 1, 0, 4, 1'b0};
    rows[3] = '{1'b0, 10, 4, 0, 1'b0, 1'b0, 9, 25, 4, 0, 0, 1, 1, 1'b1};
    rows[4] = '{1'b0, 0,  9, 0, 1'b1, 1'b0, 9, 25, 9, 1, 1, 0, 1, 1'b0};
    rows[5] = '{1'b1, 2,  9, 1, 1'b0, 1'b1, 9, 25, 9, 1, 1, 0, 2, 1'b0};

    reset = 1'b0; start = 1'b0;
    ker_valid = 1'b0; ker_data = '0; px_valid = 1'b0; px_data = '0;
    kforce = 1'b1;
    repeat (3) step();
    chk("reset_ctrl", {23'd0, ovec()}, 32'd0);
    chk("reset_res_data", res_data, 32'd0);
    chk("reset_dp_kernel_in", dp_kernel_in, 32'd0);
    chk("reset_dp_data_in", dp_data_in, 32'd0);
    reset = 1'b1;
    step();
    chk("idle_dp_reset", {31'd0, dp_reset}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // kdone held high since reset for the first frame, then the table.
    run_frame(rows[4], -1);
    check_row(rows[4], 40);
    for (int i = 0; i < 6; i++) begin
      run_frame(rows[i], -1);
      check_row(rows[i], i);
    end

    run_frame(rows[0], 12);
    step();
    chk("post_abort_busy", {31'd0, busy}, 32'd0);
    run_frame(rows[0], -1);
    check_row(rows[0], 99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/conv2d_seq_ctrl.md
Name: conv2d_seq_ctrl

Overview:
- Frame-level sequencer for the 3x3 conv2d datapath (line buffer + kernel register + ALU + ReLU).
- Per frame, on a start pulse it:
  - clears the datapath;
  - loads 9 kernel words from a ready/valid source;
  - streams IMG_W*IMG_H pixels into the datapath;
  - counts the (IMG_W-2)*(IMG_H-2) results, tagging the last one;
  - reports done or timeout.
- Sits between the DMA/feature-map buffers and one conv2d instance.

Parameters:
- IMG_W, 28, frame width in pixels (>=3).
- IMG_H, 28, frame height in pixels (>=3).
- KWORDS, 9, kernel words per frame.
- DRAIN_TIMEOUT, 256, maximum cycles in DRAIN with no datapath valid_out before error.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle frame start request; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful frame completion.
- error  out  1  sticky timeout flag; cleared by reset or by accepted start.
- ker_data  in  32  kernel word from source.
- ker_valid  in  1  kernel word valid.
- ker_ready  out  1  controller accepts kernel word.
- px_data  in  32  pixel from source.
- px_valid  in  1  pixel valid.
- px_ready  out  1  controller accepts pixel.
- dp_reset  out  1  datapath reset, active-low.
- dp_kernel_in  out  32  kernel word to datapath.
- dp_data_in  out  32  pixel to datapath.
- dp_valid_in  out  1  pixel strobe to datapath.
- dp_load_kernel_done  in  1  datapath kernel register full.
- dp_valid_out  in  1  datapath result valid.
- dp_data_out  in  32  datapath result.
- res_data  out  32  registered result.
- res_valid  out  1  registered result valid.
- res_last  out  1  marks final result of frame.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; all counters 0.
  - busy, done, error, ker_ready, px_ready, dp_valid_in, res_valid and res_last = 0.
  - dp_reset=0; res_data=0, dp_kernel_in=0, dp_data_in=0.
- States: IDLE, CLEAR, LOAD_K, WAIT_K, STREAM, DRAIN, FIN.
- IDLE:
  - dp_reset=1.
  - start=1 -> CLEAR, clears error.
- CLEAR (1 cycle):
  - dp_reset=0 to flush line buffer and kernel register.
  - -> LOAD_K.
- LOAD_K:
  - ker_ready=1; each ker_valid&ker_ready cycle:
    - registers ker_data onto dp_kernel_in;
    - increments kcnt.
  - On the KWORDS-th accept -> WAIT_K; ker_ready drops the next cycle.
  - ker_valid low: stall with no timeout.
- WAIT_K:
  - Holds until dp_load_kernel_done=1, then -> STREAM.
  - If dp_load_kernel_done is already 1 on entry, leaves WAIT_K after exactly 1 cycle.
- STREAM:
  - px_ready=1; on px_valid&px_ready:
    - dp_data_in<=px_data, dp_valid_in<=1 (registered, 1-cycle skid);
    - pcnt++.
  - Otherwise dp_valid_in<=0.
  - Accept number IMG_W*IMG_H -> DRAIN; px_ready=0 from the next cycle.
- Results in STREAM and DRAIN:
  - Each dp_valid_out=1 cycle: res_data<=dp_data_out, res_valid<=1, ocnt++.
  - res_last<=1 when ocnt reaches (IMG_W-2)*(IMG_H-2)-1 before increment.
  - Results arriving in IDLE/CLEAR/LOAD_K/WAIT_K are dropped (res_valid stays 0).
- DRAIN:
  - Idle counter resets on every dp_valid_out and increments otherwise.
  - Final result seen -> FIN.
  - Idle counter == DRAIN_TIMEOUT -> error<=1, -> FIN.
- FIN (1 cycle):
  - done=1 only if error=0.
  - -> IDLE.
- Counter widths are $clog2 of the maximum count + 1; no wrap within a legal frame.
- The result count is compared only against the fixed target.
- If ocnt would exceed the target (extra results), the surplus is ignored and res_valid stays 0.
- start while busy: ignored, no queueing.
- Reset mid-frame: immediate return to IDLE; dp_reset is driven low in that cycle via reset, and partial counts are discarded.
- The datapath has no backpressure; the result sink must accept every res_valid cycle.

Test Plan:
- IMG_W=IMG_H=5, start, 9 kernel words 1..9 back-to-back, 25 pixels back-to-back:
  - ker_ready high exactly 9 accepts; dp_valid_in pulses 25 times;
  - exactly 9 res_valid with res_last on the 9th; done pulses once; error=0.
- Same frame with ker_valid and px_valid toggling 1-0 every cycle:
  - counts unchanged (9/25/9);
  - dp_valid_in never asserted in a cycle without a prior accept.
- Datapath model that withholds dp_valid_out after 4 results, DRAIN_TIMEOUT=16:
  - error=1 exactly 16 idle cycles after the last result; done stays 0; busy falls 1 cycle later.
- start pulsed during STREAM and again in FIN:
  - both ignored; only one done.
- reset=0 asserted for 1 cycle mid-STREAM after 12 pixels:
  - all outputs take reset values the next cycle;
  - a fresh start runs a full clean frame with pcnt restarting from 0.
- dp_load_kernel_done held high from reset:
  - WAIT_K lasts exactly 1 cycle;
  - CLEAR still drives dp_reset=0 for exactly 1 cycle.
